// File: rtl/led_cnt_pkg.sv
// Shared mode encodings and helpers for the LED mod-N counter.
package led_cnt_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_WRAP     = 2'd0;
  localparam mode_t MODE_ONESHOT  = 2'd1;
  localparam mode_t MODE_PINGPONG = 2'd2;

  typedef enum logic {
    PP_UP   = 1'b0,
    PP_DOWN = 1'b1
  } pp_dir_t;

  // Encoding 3 is an alias of WRAP; fold it so the count logic sees three modes.
  function automatic mode_t norm_mode(input mode_t m);
    return (m == 2'd3) ? MODE_WRAP : m;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: asserts tick on the enabled cycle where the phase counter reaches presc.
module led_tick_gen #(
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
    end else if (clr || tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/led_mod_counter.sv
// Mod-N LED counter: WRAP / ONESHOT / PINGPONG with prescaler, load and tc pulse.
// Define LEDCNT_GRAY_EN to drive the LEDs with the Gray code of the top count bits.
module led_mod_counter
  import led_cnt_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned LED_W   = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic [CNT_W-1:0]   limit,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  output logic [CNT_W-1:0]   cnt,
  output logic [LED_W-1:0]   leds,
  output logic               tc,
  output logic               done
);

  logic             tick;
  mode_t            mode_n;
  pp_dir_t          pp_dir;
  pp_dir_t          pp_dir_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             term;

  led_tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .presc (presc),
    .clr   (load),
    .tick  (tick)
  );

  assign mode_n = norm_mode(mode);

  function automatic logic [LED_W-1:0] led_map(input logic [CNT_W-1:0] c);
    logic [LED_W-1:0] g;
    g = c[CNT_W-1 -: LED_W];
`ifdef LEDCNT_GRAY_EN
    return g ^ (g >> 1);
`else
    return g;
`endif
  endfunction

  // Next-count datapath: load beats tick; a tick applies the active mode's step rule.
  always_comb begin
    cnt_nxt    = cnt;
    tc_nxt     = 1'b0;
    done_nxt   = done;
    pp_dir_nxt = pp_dir;
    term       = 1'b0;

    if (mode_n != MODE_ONESHOT) begin
      done_nxt = 1'b0;
    end

    if (load) begin
      cnt_nxt    = (load_val > limit) ? limit : load_val;
      done_nxt   = 1'b0;
      pp_dir_nxt = PP_UP;
    end else if (tick) begin
      case (mode_n)
        MODE_PINGPONG: begin
          if (limit == '0) begin
            // Degenerate range: hold at zero and pulse tc every tick.
            cnt_nxt    = '0;
            tc_nxt     = 1'b1;
            pp_dir_nxt = PP_UP;
          end else if (pp_dir == PP_UP) begin
            if (cnt >= limit) begin
              cnt_nxt    = limit - CNT_W'(1);
              tc_nxt     = 1'b1;
              pp_dir_nxt = PP_DOWN;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == '0) begin
              cnt_nxt    = CNT_W'(1);
              tc_nxt     = 1'b1;
              pp_dir_nxt = PP_UP;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          if (!done) begin
            term = dir ? (cnt == '0) : (cnt >= limit);
            if (term) begin
              cnt_nxt  = '0;
              tc_nxt   = 1'b1;
              done_nxt = 1'b1;
            end else begin
              cnt_nxt = dir ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
            end
          end
        end
        default: begin
          term = dir ? (cnt == '0) : (cnt >= limit);
          if (term) begin
            cnt_nxt = dir ? limit : '0;
            tc_nxt  = 1'b1;
          end else begin
            cnt_nxt = dir ? (cnt - CNT_W'(1)) : (cnt + CNT_W'(1));
          end
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      leds   <= '0;
      tc     <= 1'b0;
      done   <= 1'b0;
      pp_dir <= PP_UP;
    end else begin
      cnt    <= cnt_nxt;
      leds   <= led_map(cnt_nxt);
      tc     <= tc_nxt;
      done   <= done_nxt;
      pp_dir <= pp_dir_nxt;
    end
  end

endmodule
